// File: rtl/wide_add_sequencer.sv
// wide_add_sequencer
//
// Adds or subtracts two NUM_WORDS x 32-bit operands by running them one
// 32-bit word at a time through an external 32-bit adder. Word 0 (bits
// [31:0]) goes first and the carry is threaded from word to word through a
// carry register. A result is presented NUM_WORDS cycles after acceptance
// and is held until the consumer takes it.
//
// Handshake (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. in_ready is 1 only in IDLE. out_valid is 1
// only in DONE, and out_sum/out_cout/out_ovf hold stable until the edge
// that sees out_ready=1.
//
// Ports
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake
//   in_a, in_b          operands, W = 32*NUM_WORDS bits
//   in_cin              carry-in for add mode
//   in_sub              1: A-B, 0: A+B+cin
//   add_a/add_b/add_cin operands driven to the external 32-bit adder
//   add_sum/add_cout    combinational result from that adder
//   out_valid/out_ready result handshake
//   out_sum, out_cout   W-bit result and raw carry out of the last word
//   out_ovf             signed overflow flag
//   dbg_state           current FSM state (0 IDLE, 1 RUN, 2 DONE)
module wide_add_sequencer #(
  parameter int NUM_WORDS = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [32*NUM_WORDS-1:0]   in_a,
  input  logic [32*NUM_WORDS-1:0]   in_b,
  input  logic                      in_cin,
  input  logic                      in_sub,
  output logic [31:0]               add_a,
  output logic [31:0]               add_b,
  output logic                      add_cin,
  input  logic [31:0]               add_sum,
  input  logic                      add_cout,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [32*NUM_WORDS-1:0]   out_sum,
  output logic                      out_cout,
  output logic                      out_ovf,
  output logic [1:0]                dbg_state
);

  localparam int W  = 32 * NUM_WORDS;
  localparam int KW = $clog2(NUM_WORDS);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_sub;
  logic            r_cin;
  logic [KW-1:0]   r_k;
  logic            r_carry;
  logic [W-1:0]    r_sum;
  logic            r_ovf;

  logic [KW+4:0]   w_base;
  logic [31:0]     w_word_a;
  logic [31:0]     w_word_b;
  logic            w_last;
  logic            w_take;

  // Bit offset of word k; k*32 built by concatenation keeps widths exact.
  assign w_base   = {r_k, 5'b00000};
  assign w_word_a = r_a[w_base +: 32];
  // Subtraction is A + ~B + 1; the +1 enters as the word-0 carry-in.
  assign w_word_b = r_b[w_base +: 32] ^ {32{r_sub}};
  assign w_last   = (r_k == KW'(NUM_WORDS - 1));
  assign w_take   = in_valid && in_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state and FSM-decoded outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = 32'd0;
    add_b     = 32'd0;
    add_cin   = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        add_a   = w_word_a;
        add_b   = w_word_b;
        add_cin = (r_k == '0) ? (r_sub ? 1'b1 : r_cin) : r_carry;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Operand capture is not reset: it is always reloaded before use.
  always_ff @(posedge clk) begin
    if (!rst && w_take) begin
      r_a   <= in_a;
      r_b   <= in_b;
      r_sub <= in_sub;
      r_cin <= in_cin;
    end
  end

  // Word sequencing and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_k     <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_ovf   <= 1'b0;
    end else if (w_take) begin
      r_k <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[w_base +: 32] <= add_sum;
      r_carry             <= add_cout;
      r_k                 <= r_k + KW'(1);
      // On the top word, w_word_b[31] is the msb of the possibly inverted B.
      if (w_last) begin
        r_ovf <= (w_word_a[31] == w_word_b[31]) && (add_sum[31] != w_word_a[31]);
      end
    end
  end

  assign out_sum   = r_sum;
  assign out_cout  = r_carry;
  assign out_ovf   = r_ovf;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// Testbench for wide_add_sequencer with NUM_WORDS=4 and a behavioural
// 32-bit adder attached to the add_* ports.
module tb_wide_add_sequencer;

  localparam int NUM_WORDS = 4;
  localparam int W = 32 * NUM_WORDS;
  typedef logic [W+1:0] chk_t;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   in_a;
  logic [W-1:0]   in_b;
  logic           in_cin;
  logic           in_sub;
  logic [31:0]    add_a;
  logic [31:0]    add_b;
  logic           add_cin;
  logic [31:0]    add_sum;
  logic           add_cout;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_sum;
  logic           out_cout;
  logic           out_ovf;
  logic [1:0]     dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  // Scoreboard: {ovf, cout, sum} per accepted operation, in order.
  logic [W+1:0] exp_q[$];

  wide_add_sequencer #(.NUM_WORDS(NUM_WORDS)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf),
    .dbg_state(dbg_state)
  );

  // External 32-bit adder
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'd0, add_cin};

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input chk_t obs, input chk_t exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [W-1:0] v;
    for (int i = 0; i < NUM_WORDS; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  // Reference: whole-width arithmetic, then the signed-overflow rule.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic s, input logic c);
    logic [W:0]   full;
    logic [W-1:0] sum;
    logic         cout;
    logic         bmsb;
    logic         ovf;
    if (s) begin
      sum  = a - b;
      cout = (a >= b);
      bmsb = ~b[W-1];
    end else begin
      full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, c};
      sum  = full[W-1:0];
      cout = full[W];
      bmsb = b[W-1];
    end
    ovf = (a[W-1] == bmsb) && (sum[W-1] != a[W-1]);
    return {ovf, cout, sum};
  endfunction

  // Driver: present operands with in_valid high until the block is ready,
  // then let the accepting edge pass. Called and returns at a negedge.
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic c);
    int guard;
    in_a = a; in_b = b; in_sub = s; in_cin = c; in_valid = 1'b1;
    exp_q.push_back(model(a, b, s, c));
    guard = 0;
    while (!in_ready && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    check("send_ready_timeout", chk_t'(in_ready), chk_t'(1));
    @(negedge clk);
    in_valid = 1'b0;
    check("run_in_ready", chk_t'(in_ready), chk_t'(0));
    check("run_add_a_w0", chk_t'(add_a), chk_t'(a[31:0]));
    check("run_add_cin_w0", chk_t'(add_cin), chk_t'(s ? 1'b1 : c));
  endtask

  // Wait for the result with junk on the inputs, check latency and value.
  task automatic collect(output logic [W+1:0] got_exp);
    int cnt;
    cnt = 0;
    got_exp = '0;
    while (!out_valid && cnt < 20) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = rand_w(); in_b = rand_w();
      in_sub = 1'($urandom_range(0, 1)); in_cin = 1'($urandom_range(0, 1));
      @(negedge clk);
      cnt++;
    end
    in_valid = 1'b0;
    check("result_latency", chk_t'(cnt), chk_t'(NUM_WORDS));
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", chk_t'(0), chk_t'(1));
      return;
    end
    got_exp = exp_q.pop_front();
    check("sum", chk_t'(out_sum), chk_t'(got_exp[W-1:0]));
    check("cout", chk_t'(out_cout), chk_t'(got_exp[W]));
    check("ovf", chk_t'(out_ovf), chk_t'(got_exp[W+1]));
    check("done_add_a_zero", chk_t'({add_cin, add_b, add_a}), chk_t'(0));
    if (out_ready) begin
      @(negedge clk);
      check("after_take_valid", chk_t'(out_valid), chk_t'(0));
      check("after_take_ready", chk_t'(in_ready), chk_t'(1));
    end
  endtask

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic s, input logic c);
    logic [W+1:0] e;
    send(a, b, s, c);
    collect(e);
  endtask

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] v;
    logic [W+1:0] e;
    int seen;

    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_out_valid", chk_t'(out_valid), chk_t'(0));
    check("rst_out_sum", chk_t'(out_sum), chk_t'(0));
    check("rst_out_flags", chk_t'({out_cout, out_ovf}), chk_t'(0));
    check("rst_adder_ports", chk_t'({add_cin, add_b, add_a}), chk_t'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", chk_t'(in_ready), chk_t'(1));

    // Directed corner cases
    ones = '1;
    do_op(ones, W'(1), 1'b0, 1'b0);
    v = '1; v[W-1] = 1'b0;
    do_op(v, W'(1), 1'b0, 1'b0);
    do_op(W'(5), W'(7), 1'b1, 1'b0);
    do_op(W'(7), W'(5), 1'b1, 1'b0);
    do_op(ones, ones, 1'b0, 1'b1);
    do_op(W'(0), W'(0), 1'b1, 1'b0);

    // Random operations
    for (int i = 0; i < 20; i++) begin
      do_op(rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    end

    // Result held while the consumer stalls
    out_ready = 1'b0;
    send(rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    collect(e);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_a = rand_w(); in_b = rand_w();
      @(negedge clk);
      check("stall_valid", chk_t'(out_valid), chk_t'(1));
      check("stall_in_ready", chk_t'(in_ready), chk_t'(0));
      check("stall_sum", chk_t'(out_sum), chk_t'(e[W-1:0]));
      check("stall_flags", chk_t'({out_ovf, out_cout}), chk_t'(e[W+1:W]));
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", chk_t'(out_valid), chk_t'(0));
    check("stall_release_ready", chk_t'(in_ready), chk_t'(1));

    // Reset while processing word 2 aborts the operation
    send(rand_w(), rand_w(), 1'b0, 1'b1);
    void'(exp_q.pop_back());
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_valid", chk_t'(out_valid), chk_t'(0));
    check("abort_sum", chk_t'(out_sum), chk_t'(0));
    check("abort_cout", chk_t'(out_cout), chk_t'(0));
    check("abort_in_ready", chk_t'(in_ready), chk_t'(1));
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("abort_no_valid", chk_t'(seen), chk_t'(0));
    do_op(rand_w(), rand_w(), 1'b1, 1'b0);

    // in_valid during reset is ignored
    rst = 1'b1; in_valid = 1'b1; in_a = rand_w(); in_b = rand_w();
    @(negedge clk);
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_ignores_valid_ready", chk_t'(in_ready), chk_t'(1));
    check("rst_ignores_valid_out", chk_t'(out_valid), chk_t'(0));

    // Back-to-back with out_ready high: one result every NUM_WORDS+2 cycles
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          send(rand_w(), rand_w(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
      end
      begin
        int prev;
        int cnt;
        logic [W+1:0] x;
        prev = 0;
        for (int i = 0; i < 8; i++) begin
          cnt = 0;
          while (!out_valid && cnt < 30) begin
            @(negedge clk);
            cnt++;
          end
          if (!out_valid) begin
            check("b2b_timeout", chk_t'(0), chk_t'(1));
            break;
          end
          if (i > 0) check("b2b_gap", chk_t'(cyc - prev), chk_t'(NUM_WORDS + 2));
          prev = cyc;
          x = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
          check("b2b_sum", chk_t'(out_sum), chk_t'(x[W-1:0]));
          check("b2b_flags", chk_t'({out_ovf, out_cout}), chk_t'(x[W+1:W]));
          @(negedge clk);
        end
      end
    join
    check("scoreboard_drained", chk_t'(exp_q.size()), chk_t'(0));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/wide_add_sequencer.md
WIDE_ADD_SEQUENCER -- requirements
Module: wide_add_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_WORDS, default 4, giving the number of 32-bit words per operand (operand width W = 32*NUM_WORDS; legal range 2..16).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, a synchronous active-high reset.
REQ-004 The block SHALL have port in_valid, input, 1, meaning the upstream operand set is valid.
REQ-005 The block SHALL have port in_ready, output, 1, meaning the block accepts an operand set.
REQ-006 The block SHALL have ports in_a and in_b, input, W each, the operands, with word 0 at bits [31:0].
REQ-007 The block SHALL have port in_cin, input, 1, the carry-in for add mode.
REQ-008 The block SHALL have port in_sub, input, 1; 1 selects A-B, 0 selects A+B+cin.
REQ-009 The block SHALL have ports add_a and add_b, output, 32 each, and add_cin, output, 1, which drive the downstream 32-bit carry-select adder.
REQ-010 The block SHALL have ports add_sum, input, 32, and add_cout, input, 1, the adder's combinational result.
REQ-011 The block SHALL have ports out_valid, output, 1, and out_ready, input, 1, the result handshake.
REQ-012 The block SHALL have ports out_sum, output, W; out_cout, output, 1; and out_ovf, output, 1, the signed overflow flag.

Function
REQ-013 The FSM SHALL have three states, IDLE, RUN and DONE, and rst SHALL force it to IDLE.
REQ-014 The in_ready output SHALL be 1 only in IDLE; a transfer occurs at a rising edge with in_valid=1 and in_ready=1.
REQ-015 On transfer, the block SHALL register in_a, in_b, in_sub and in_cin, set word index k=0, and enter RUN.
REQ-016 In RUN, add_a SHALL equal reg_a word k, and add_b SHALL equal reg_b word k, or its bitwise inverse when sub=1.
REQ-017 In RUN, add_cin SHALL be (sub ? 1 : cin) when k=0, and carry_reg otherwise.
REQ-018 Each RUN edge SHALL write add_sum into out_sum word k, load carry_reg with add_cout, and increment k.
REQ-019 The edge that processes k=NUM_WORDS-1 SHALL enter DONE; the result SHALL therefore appear NUM_WORDS cycles after acceptance.
REQ-020 In DONE, out_valid SHALL be 1, out_cout SHALL equal carry_reg, and out_ovf SHALL be (a_msb==b'_msb) && (sum_msb!=a_msb), where b' is the possibly inverted B.
REQ-021 In DONE, the edge with out_ready=1 SHALL return the FSM to IDLE; out_sum, out_cout and out_ovf SHALL hold stable until that edge.
REQ-022 Outside RUN, add_a, add_b and add_cin SHALL be 0.
REQ-023 Changes to in_* during RUN or DONE SHALL have no effect.
REQ-024 Per-operation throughput SHALL be one result per NUM_WORDS+2 cycles when out_ready is held high.
REQ-025 out_cout SHALL be the raw carry from the last word; in sub mode, 1 means no borrow.

Reset
REQ-026 When rst=1 at an edge, the block SHALL set the state to IDLE, k=0, carry_reg=0, out_sum=0, out_cout=0, out_ovf=0 and out_valid=0; in_ready=1 SHALL follow in the next cycle.
REQ-027 Reset asserted in RUN or DONE SHALL abort the operation, produce no out_valid, and discard the partial sum.
REQ-028 When rst=1 at an edge, in_valid SHALL be ignored.

Verification (NUM_WORDS=4, with an instance of the 32-bit adder attached)
REQ-029 The bench SHALL cover: A=2^128-1, B=1, cin=0, add -> out_valid 4 cycles after acceptance, sum=0, cout=1, ovf=0.
REQ-030 The bench SHALL cover: A=0x7FFF...FF, B=1, add -> sum=0x8000...00, cout=0, ovf=1.
REQ-031 The bench SHALL cover: sub, A=5, B=7 -> sum=2^128-2, cout=0, ovf=0; and sub, A=7, B=5 -> sum=2, cout=1.
REQ-032 The bench SHALL cover: out_ready held low for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; IDLE after out_ready=1.
REQ-033 The bench SHALL cover: rst asserted at k=2 -> next cycle IDLE, out_valid=0, out_sum=0; a following operation yields the correct result.
REQ-034 The bench SHALL cover: back-to-back in_valid with out_ready=1 -> one result every 6 cycles, operands matched in order against a reference model.
